v_rf_banked: RTL and testbench
==============================

Name: v_rf_banked

Overview:
- Multi-register successor to the single-vector banked register: holds num_regs_p vector registers of vlen_p elements each, striped across lanes_p banks.
- Each bank has one read port and one write port.
- Per-lane valid/ready request ports with per-bank round-robin arbitration serialise bank conflicts instead of silently mis-steering them.
- Registered read data (1-cycle latency) and synchronous clear on reset.
- Sits between the vector lane datapaths and the issue/sequencer logic.

Parameters:
- num_regs_p, 8, number of vector registers; power of two, >=2.
- vlen_p, 8, elements per vector register; multiple of lanes_p.
- vdw_p, 32, bits per element.
- lanes_p, 4, lanes = banks; power of two, >=2.
- Derived: reg_width_lp = clog2(num_regs_p); addr_width_lp = clog2(vlen_p); lane_addr_width_lp = clog2(lanes_p); els_per_bank_lp = vlen_p/lanes_p; bank_addr_width_lp = safe_clog2(els_per_bank_lp).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
- r_v_i  in  lanes_p  per-lane read request valid.
- r_reg_i  in  lanes_p x reg_width_lp  read register index.
- r_addr_i  in  lanes_p x addr_width_lp  read element index.
- r_ready_o  out  lanes_p  read request granted this cycle.
- r_v_o  out  lanes_p  read data valid (1 cycle after grant).
- r_data_o  out  lanes_p x vdw_p  read data.
- w_v_i  in  lanes_p  per-lane write request valid.
- w_reg_i  in  lanes_p x reg_width_lp  write register index.
- w_addr_i  in  lanes_p x addr_width_lp  write element index.
- w_data_i  in  lanes_p x vdw_p  write data.
- w_ready_o  out  lanes_p  write request granted (committed at this edge).

Behaviour:
- Clock and reset: single clock clk_i. reset_i is synchronous and active-high.
- Mapping:
  - bank = addr[lane_addr_width_lp-1:0].
  - Row within bank = {reg, addr >> lane_addr_width_lp}.
  - Bank depth = num_regs_p*els_per_bank_lp.
- Handshake: a request transfers when v_i & ready_o in the same cycle. Until granted, the requester holds reg/addr/data stable. ready_o is combinational from v_i, addresses and arbiter state. No dependence of v_i on ready_o is permitted.
- Arbitration:
  - Reads and writes use independent arbiters, one pair per bank.
  - Per bank, each arbiter holds a pointer ptr (lane_addr_width_lp bits; reset 0).
  - Winner = first requesting lane scanning ptr, ptr+1, ... modulo lanes_p.
  - On grant, ptr <= winner+1 mod lanes_p. No grant leaves ptr unchanged.
  - At most one read grant and one write grant per bank per cycle.
- Write: a granted write commits at the clock edge and is visible to reads granted in the following cycle or later.
- Read:
  - Granted in cycle N, the bank is read in cycle N. r_data_o[i] and r_v_o[i]=1 are registered and appear in cycle N+1.
  - r_v_o[i]=0 in any cycle following a non-grant. r_data_o[i] holds its last value.
- Same-cycle read and write to the same row: the read returns the OLD contents (read-before-write). No bypass.
- Two lanes writing different rows of different banks: both commit. Two lanes writing the same bank: one winner per cycle; the loser retries.
- Reset:
  - Every storage element clears to 0.
  - r_v_o=0, r_data_o=0, all ptr=0.
  - r_ready_o=0 and w_ready_o=0 while reset_i=1.
  - A read granted in the cycle reset asserts produces no r_v_o.
  - A write presented during reset is dropped.
- Starvation bound: a lane continuously requesting a bank is granted within lanes_p cycles.

Decomposition:
- Shared package v_rf_pkg:
  - lane/bank index and row-address width helper functions.
  - Request struct typedef {reg, addr}.
  - Mapping function bank_of(addr) / row_of(reg, addr) used by both the RTL and the testbench model.
- One sub-module: v_rf_rr_arb (lanes_p-input round-robin arbiter with ptr register, one-hot grant, grant_v). Instantiated 2*lanes_p times.

Test Plan:
- Reset, then lanes 0..3 read reg 0 addr 0..3 -> all r_ready_o=1; next cycle r_v_o=4'b1111, r_data_o all 0.
- Write reg 2 addr 5 data 0xDEADBEEF (lane 1), next cycle lane 3 reads reg 2 addr 5 -> 1 cycle later r_data_o[3]=0xDEADBEEF, r_v_o[3]=1.
- Lanes 0..3 all read addresses in bank 1 (addr 1, 5, reg 0..3) held valid -> r_ready_o grants lanes 0, 1, 2, 3 in successive cycles (one-hot per cycle, ptr 0 -> 1 -> 2 -> 3 -> 0); each r_v_o pulses once.
- Same cycle: lane 0 writes reg 1 addr 2 = 0x11 (prior value 0x22), lane 2 reads reg 1 addr 2 -> read returns 0x22; a read the following cycle returns 0x11.
- Lanes 0 and 2 both write bank 3, held for 4 cycles with lane 0 re-requesting after its grant -> grants alternate 0, 2, 0, 2; final contents match the last granted data.
- reset_i asserted while lane 1 read is granted and lane 0 write pending -> next cycle r_v_o=0; subsequent reads of the written location return 0.

Source files
------------

// File: rtl/v_rf_pkg.sv
// Shared widths, request payload and element-to-bank mapping for the banked
// vector register file; the same mapping functions are used by its model.
package v_rf_pkg;

   localparam int unsigned req_reg_width_lp  = 3;
   localparam int unsigned req_addr_width_lp = 3;

   typedef struct packed {
      logic [req_reg_width_lp-1:0]  rf_reg;
      logic [req_addr_width_lp-1:0] addr;
   } rf_req_t;

   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Elements are striped so that consecutive elements land in consecutive banks.
   function automatic int unsigned bank_of(input int unsigned addr,
                                           input int unsigned lanes);
      return addr % lanes;
   endfunction

   function automatic int unsigned row_of(input int unsigned rf_reg,
                                          input int unsigned addr,
                                          input int unsigned lanes,
                                          input int unsigned bank_aw);
      return (rf_reg << bank_aw) | (addr / lanes);
   endfunction

endpackage

// File: rtl/v_rf_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module v_rf_rr_arb #(
   parameter int unsigned lanes_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [lanes_p-1:0] req_i,
   output logic [lanes_p-1:0] grant_c_o,
   output logic               grant_v_c_o
);

   localparam int unsigned ptr_width_lp = $clog2(lanes_p);

   logic [ptr_width_lp-1:0] ptr_q;
   logic [ptr_width_lp-1:0] winner;
   logic [ptr_width_lp-1:0] idx;

   always_comb begin
      grant_c_o   = '0;
      grant_v_c_o = 1'b0;
      winner      = ptr_q;
      idx         = '0;
      for (int k = 0; k < int'(lanes_p); k++) begin
         idx = ptr_q + ptr_width_lp'(k);
         if (!grant_v_c_o && req_i[idx]) begin
            grant_c_o[idx] = 1'b1;
            grant_v_c_o    = 1'b1;
            winner         = idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         ptr_q <= '0;
      else if (grant_v_c_o)
         ptr_q <= winner + ptr_width_lp'(1);
   end

endmodule

// File: rtl/v_rf_banked.sv
// Multi-register vector register file striped over lanes_p single-read,
// single-write banks with per-bank round-robin arbitration of lane requests.
module v_rf_banked
   import v_rf_pkg::*;
#(
   parameter  int unsigned num_regs_p         = 8,
   parameter  int unsigned vlen_p             = 8,
   parameter  int unsigned vdw_p              = 32,
   parameter  int unsigned lanes_p            = 4,
   localparam int unsigned reg_width_lp       = $clog2(num_regs_p),
   localparam int unsigned addr_width_lp      = $clog2(vlen_p),
   localparam int unsigned lane_addr_width_lp = $clog2(lanes_p),
   localparam int unsigned els_per_bank_lp    = vlen_p / lanes_p,
   localparam int unsigned bank_addr_width_lp = safe_clog2(els_per_bank_lp)
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [lanes_p-1:0]                     r_v_i,
   input  logic [lanes_p-1:0][reg_width_lp-1:0]   r_reg_i,
   input  logic [lanes_p-1:0][addr_width_lp-1:0]  r_addr_i,
   output logic [lanes_p-1:0]                     r_ready_o,
   output logic [lanes_p-1:0]                     r_v_o,
   output logic [lanes_p-1:0][vdw_p-1:0]          r_data_o,
   input  logic [lanes_p-1:0]                     w_v_i,
   input  logic [lanes_p-1:0][reg_width_lp-1:0]   w_reg_i,
   input  logic [lanes_p-1:0][addr_width_lp-1:0]  w_addr_i,
   input  logic [lanes_p-1:0][vdw_p-1:0]          w_data_i,
   output logic [lanes_p-1:0]                     w_ready_o
);

   localparam int unsigned row_width_lp = reg_width_lp + bank_addr_width_lp;
   localparam int unsigned depth_lp     = 1 << row_width_lp;

   logic [lanes_p-1:0] r_gnt_bank [lanes_p];
   logic [lanes_p-1:0] w_gnt_bank [lanes_p];
   logic [vdw_p-1:0]   bank_rdata [lanes_p];

   for (genvar b = 0; b < int'(lanes_p); b++) begin : g_bank
      logic [lanes_p-1:0]      r_req;
      logic [lanes_p-1:0]      w_req;
      logic                    r_gv;
      logic                    w_gv;
      logic [row_width_lp-1:0] rd_row;
      logic [row_width_lp-1:0] wr_row;
      logic [vdw_p-1:0]        wr_data;
      logic [vdw_p-1:0]        mem [depth_lp];

      // Requests are masked during reset so nothing is granted or committed.
      always_comb begin
         r_req = '0;
         w_req = '0;
         for (int l = 0; l < int'(lanes_p); l++) begin
            if (!reset_i && r_v_i[l] && bank_of(32'(r_addr_i[l]), lanes_p) == 32'(b))
               r_req[l] = 1'b1;
            if (!reset_i && w_v_i[l] && bank_of(32'(w_addr_i[l]), lanes_p) == 32'(b))
               w_req[l] = 1'b1;
         end
      end

      v_rf_rr_arb #(.lanes_p(lanes_p)) u_r_arb (
         .clk_i      (clk_i),
         .reset_i    (reset_i),
         .req_i      (r_req),
         .grant_c_o  (r_gnt_bank[b]),
         .grant_v_c_o(r_gv)
      );

      v_rf_rr_arb #(.lanes_p(lanes_p)) u_w_arb (
         .clk_i      (clk_i),
         .reset_i    (reset_i),
         .req_i      (w_req),
         .grant_c_o  (w_gnt_bank[b]),
         .grant_v_c_o(w_gv)
      );

      // Steer the winning lane's row and data onto the bank ports.
      always_comb begin
         rd_row  = '0;
         wr_row  = '0;
         wr_data = '0;
         for (int l = 0; l < int'(lanes_p); l++) begin
            if (r_gnt_bank[b][l])
               rd_row = row_width_lp'(row_of(32'(r_reg_i[l]), 32'(r_addr_i[l]),
                                             lanes_p, bank_addr_width_lp));
            if (w_gnt_bank[b][l]) begin
               wr_row  = row_width_lp'(row_of(32'(w_reg_i[l]), 32'(w_addr_i[l]),
                                              lanes_p, bank_addr_width_lp));
               wr_data = w_data_i[l];
            end
         end
      end

      assign bank_rdata[b] = r_gv ? mem[rd_row] : '0;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            for (int i = 0; i < int'(depth_lp); i++)
               mem[i] <= '0;
         end else if (w_gv) begin
            mem[wr_row] <= wr_data;
         end
      end
   end

   always_comb begin
      r_ready_o = '0;
      w_ready_o = '0;
      for (int bk = 0; bk < int'(lanes_p); bk++) begin
         r_ready_o = r_ready_o | r_gnt_bank[bk];
         w_ready_o = w_ready_o | w_gnt_bank[bk];
      end
   end

   // Read data is captured from the lane's bank in the grant cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_v_o    <= '0;
         r_data_o <= '0;
      end else begin
         r_v_o <= r_ready_o;
         for (int l = 0; l < int'(lanes_p); l++) begin
            if (r_ready_o[l])
               r_data_o[l] <= bank_rdata[lane_addr_width_lp'(bank_of(32'(r_addr_i[l]), lanes_p))];
         end
      end
   end

endmodule

// File: tb/tb_v_rf_banked.sv
// Randomized bench for v_rf_banked against an element-level register file
// model with per-bank round-robin grant selection.
module tb_v_rf_banked;
   import v_rf_pkg::*;

   logic                 clk;
   logic                 reset;
   logic [3:0]           r_v, r_ready, r_v_out, w_v, w_ready;
   logic [3:0][2:0]      r_reg, r_addr, w_reg, w_addr;
   logic [3:0][31:0]     w_data, r_data;

   v_rf_banked #(.num_regs_p(8), .vlen_p(8), .vdw_p(32), .lanes_p(4)) dut (
      .clk_i    (clk),
      .reset_i  (reset),
      .r_v_i    (r_v),
      .r_reg_i  (r_reg),
      .r_addr_i (r_addr),
      .r_ready_o(r_ready),
      .r_v_o    (r_v_out),
      .r_data_o (r_data),
      .w_v_i    (w_v),
      .w_reg_i  (w_reg),
      .w_addr_i (w_addr),
      .w_data_i (w_data),
      .w_ready_o(w_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_mem [8][8];
   int          ptr_r [4];
   int          ptr_w [4];
   logic [3:0]  exp_rv, gr, gw, last_rr, last_wr;
   logic [31:0] exp_rd [4];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input int p, input logic [3:0] mask);
      for (int k = 0; k < 4; k++)
         if (mask[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 8; r++)
         for (int a = 0; a < 8; a++) m_mem[r][a] = '0;
      for (int b = 0; b < 4; b++) begin ptr_r[b] = 0; ptr_w[b] = 0; end
      exp_rv = '0;
      for (int l = 0; l < 4; l++) exp_rd[l] = '0;
   endtask

   // One clock: inputs already driven at the negedge on entry; returns at the next negedge.
   task automatic cycle();
      logic [3:0] mr, mw;
      int         w;
      #1;
      gr = '0;
      gw = '0;
      if (!reset) begin
         for (int b = 0; b < 4; b++) begin
            mr = '0;
            mw = '0;
            for (int l = 0; l < 4; l++) begin
               if (r_v[l] && bank_of(32'(r_addr[l]), 4) == 32'(b)) mr[l] = 1'b1;
               if (w_v[l] && bank_of(32'(w_addr[l]), 4) == 32'(b)) mw[l] = 1'b1;
            end
            w = pick(ptr_r[b], mr);
            if (w >= 0) begin gr[w] = 1'b1; ptr_r[b] = (w + 1) % 4; end
            w = pick(ptr_w[b], mw);
            if (w >= 0) begin gw[w] = 1'b1; ptr_w[b] = (w + 1) % 4; end
         end
      end
      last_rr = r_ready;
      last_wr = w_ready;
      chk("r_ready", 64'(r_ready), 64'(gr));
      chk("w_ready", 64'(w_ready), 64'(gw));
      if (reset) begin
         model_clear();
      end else begin
         for (int l = 0; l < 4; l++)
            if (gr[l]) exp_rd[l] = m_mem[r_reg[l]][r_addr[l]];
         exp_rv = gr;
         for (int l = 0; l < 4; l++)
            if (gw[l]) m_mem[w_reg[l]][w_addr[l]] = w_data[l];
      end
      @(negedge clk);
      chk("r_v", 64'(r_v_out), 64'(exp_rv));
      for (int l = 0; l < 4; l++)
         chk($sformatf("r_data%0d", l), 64'(r_data[l]), 64'(exp_rd[l]));
   endtask

   initial begin
      rf_req_t q;
      reset = 1'b1;
      r_v = '0; w_v = '0; r_reg = '0; r_addr = '0; w_reg = '0; w_addr = '0; w_data = '0;
      model_clear();
      repeat (2) @(negedge clk);
      cycle();
      chk("rst_rv", 64'(r_v_out), 64'(0));
      reset = 1'b0;

      // All lanes read reg 0 across the four banks.
      for (int l = 0; l < 4; l++) begin r_v[l] = 1'b1; r_reg[l] = 3'd0; r_addr[l] = 3'(l); end
      cycle();
      r_v = '0;
      chk("t1_ready", 64'(last_rr), 64'(4'hf));
      chk("t1_rv", 64'(r_v_out), 64'(4'hf));
      chk("t1_data", 64'(r_data), 64'(0));

      // Write then read back on another lane.
      w_v[1] = 1'b1; w_reg[1] = 3'd2; w_addr[1] = 3'd5; w_data[1] = 32'hdeadbeef;
      cycle();
      w_v = '0;
      r_v[3] = 1'b1; r_reg[3] = 3'd2; r_addr[3] = 3'd5;
      cycle();
      r_v = '0;
      chk("t2_data", 64'(r_data[3]), 64'(32'hdeadbeef));
      chk("t2_rv", 64'(r_v_out[3]), 64'(1));

      // All lanes contend for bank 1; grants rotate from lane 0.
      for (int l = 0; l < 4; l++) begin r_v[l] = 1'b1; r_reg[l] = 3'(l); r_addr[l] = (l % 2 != 0) ? 3'd5 : 3'd1; end
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("t3_gnt", 64'(last_rr), 64'(1 << k));
         r_v = r_v & ~gr;
      end
      cycle();

      // Same-cycle read and write of one row returns the old value.
      w_v[0] = 1'b1; w_reg[0] = 3'd1; w_addr[0] = 3'd2; w_data[0] = 32'h22;
      cycle();
      w_data[0] = 32'h11;
      r_v[2] = 1'b1; r_reg[2] = 3'd1; r_addr[2] = 3'd2;
      cycle();
      w_v = '0;
      chk("t4_old", 64'(r_data[2]), 64'(32'h22));
      cycle();
      r_v = '0;
      chk("t4_new", 64'(r_data[2]), 64'(32'h11));

      // Two lanes write the same bank-3 row; grants alternate.
      w_v[0] = 1'b1; w_reg[0] = 3'd4; w_addr[0] = 3'd3; w_data[0] = 32'ha0;
      w_v[2] = 1'b1; w_reg[2] = 3'd4; w_addr[2] = 3'd3; w_data[2] = 32'hc0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("t5_gnt", 64'(last_wr), 64'((k % 2 != 0) ? 4 : 1));
         if (gw[0]) w_data[0] = w_data[0] + 32'd1;
         if (gw[2]) w_data[2] = w_data[2] + 32'd1;
      end
      w_v = '0;
      r_v[1] = 1'b1; r_reg[1] = 3'd4; r_addr[1] = 3'd3;
      cycle();
      r_v = '0;
      chk("t5_final", 64'(r_data[1]), 64'(32'hc1));

      // Reset with a read and a write presented.
      r_v[1] = 1'b1; r_reg[1] = 3'd0; r_addr[1] = 3'd1;
      w_v[0] = 1'b1; w_reg[0] = 3'd6; w_addr[0] = 3'd0; w_data[0] = 32'h55;
      reset = 1'b1;
      cycle();
      chk("t6_rv", 64'(r_v_out), 64'(0));
      reset = 1'b0;
      w_v = '0;
      r_v[1] = 1'b1; r_reg[1] = 3'd4; r_addr[1] = 3'd3;
      r_v[2] = 1'b1; r_reg[2] = 3'd6; r_addr[2] = 3'd0;
      cycle();
      r_v = '0;
      chk("t6_clr1", 64'(r_data[1]), 64'(0));
      chk("t6_clr2", 64'(r_data[2]), 64'(0));

      // Random traffic; pending requests are held until granted.
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         for (int l = 0; l < 4; l++) begin
            if (!r_v[l] && $urandom_range(0, 1) == 1) begin
               q = 6'($urandom);
               r_v[l] = 1'b1; r_reg[l] = q.rf_reg; r_addr[l] = q.addr;
            end
            if (!w_v[l] && $urandom_range(0, 1) == 1) begin
               q = 6'($urandom);
               w_v[l] = 1'b1; w_reg[l] = q.rf_reg; w_addr[l] = q.addr; w_data[l] = $urandom;
            end
         end
         cycle();
         r_v = r_v & ~gr;
         w_v = w_v & ~gw;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
